// File: rtl/booth_multiplier_pkg.sv
// Shared types and sizing for the Booth multiplier: FSM state encoding,
// default operand width and the step-counter width helper.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int count_width(input int width);
    return $clog2(width + 1);
  endfunction

  localparam int DEFAULT_COUNT_W = count_width(DEFAULT_WIDTH);

endpackage

// File: rtl/booth_multiplier_if.sv
// Start/busy/done handshake and operand/result bus between the control unit
// (master) and the Booth multiplier (slave).
interface booth_multiplier_if
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, a, b,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/booth_multiplier_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M selected by
// {Q[0], q_1}, then an arithmetic right shift of {ACC, Q, q_1}.
module booth_step
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH:0]   m,
  output logic [WIDTH:0]   acc_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_1_next
);

  logic [WIDTH:0] sum;

  always_comb begin
    case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

  // ACC carries one guard bit, so its MSB is the true sign to replicate.
  assign acc_next = {sum[WIDTH], sum[WIDTH:1]};
  assign q_next   = {sum[0], q[WIDTH-1:1]};
  assign q_1_next = q[0];

endmodule

// File: rtl/booth_multiplier.sv
// Sequential signed multiplier (radix-2 Booth, one step per clock) with a
// start/busy/done handshake. Define BOOTH_MULT_ZERO_BYPASS_EN to finish
// zero-operand requests in a single cycle.
module booth_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                reset,
  booth_multiplier_if.slave   bus
);

  localparam int CW = count_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             q1_q, q1_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;

  logic [WIDTH:0]   step_acc;
  logic [WIDTH-1:0] step_q;
  logic             step_q1;

  booth_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc_q),
    .q        (q_q),
    .q_1      (q1_q),
    .m        (m_q),
    .acc_next (step_acc),
    .q_next   (step_q),
    .q_1_next (step_q1)
  );

  // NOTE: every signal gets a default first so no path leaves it unassigned,
  // which is what keeps this block from inferring latches.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    acc_d   = acc_q;
    q_d     = q_q;
    q1_d    = q1_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
`ifdef BOOTH_MULT_ZERO_BYPASS_EN
          if (bus.a == '0 || bus.b == '0) begin
            hi_d    = '0;
            lo_d    = '0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            m_d     = {bus.a[WIDTH-1], bus.a};
            q_d     = bus.b;
            acc_d   = '0;
            q1_d    = 1'b0;
            count_d = CW'(WIDTH);
            state_d = RUN;
          end
`else
          m_d     = {bus.a[WIDTH-1], bus.a};
          q_d     = bus.b;
          acc_d   = '0;
          q1_d    = 1'b0;
          count_d = CW'(WIDTH);
          state_d = RUN;
`endif
        end
      end

      RUN: begin
        acc_d   = step_acc;
        q_d     = step_q;
        q1_d    = step_q1;
        count_d = count_q - CW'(1);
        // Final step: publish the post-shift product in the same edge.
        if (count_q == CW'(1)) begin
          hi_d    = step_acc[WIDTH-1:0];
          lo_d    = step_q;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // NOTE: state registers use non-blocking assignments so all of them
  // sample the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      m_q     <= '0;
      acc_q   <= '0;
      q_q     <= '0;
      q1_q    <= 1'b0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      q1_q    <= q1_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_booth_multiplier.sv
// Self-checking bench for booth_multiplier: directed and random products
// checked against a queue of expected results, plus handshake and reset cases.
module tb_booth_multiplier;
  import mult_pkg::*;

  localparam int W = 32;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [2*W-1:0] sb[$];
  logic [2*W-1:0] last_result;

  booth_multiplier_if #(.WIDTH(W)) bus ();

  booth_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [2*W-1:0] observed,
                       input logic [2*W-1:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [2*W-1:0] sa, sb_v;
    sa   = $signed({{W{a[W-1]}}, a});
    sb_v = $signed({{W{b[W-1]}}, b});
    return sa * sb_v;
  endfunction

  // Drives one operation at a negedge, waits (bounded) for done, compares
  // against the scoreboard head. Optionally disturbs a/b/start mid-run.
  task automatic do_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2*W-1:0] expected, input bit disturb);
    int cycles;
    int exp_lat;
    logic [2*W-1:0] head;
    exp_lat = W + 1;
`ifdef BOOTH_MULT_ZERO_BYPASS_EN
    if (a == '0 || b == '0) exp_lat = 1;
`endif
    sb.push_back(expected);
    bus.a     = a;
    bus.b     = b;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cycles = 1;
    check({tag, "_busy_after_start"}, 64'(bus.busy), 64'(1));
    while (!bus.done && cycles < W + 8) begin
      if (cycles == 10)
        check({tag, "_hold_mid_run"}, {bus.hi, bus.lo}, last_result);
      if (disturb && cycles == 5) begin
        bus.a     = $urandom;
        bus.b     = $urandom;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cycles++;
    end
    bus.start = 1'b0;
    check({tag, "_latency"}, 64'(cycles), 64'(exp_lat));
    head = sb.pop_front();
    if (bus.done) begin
      check({tag, "_product"}, {bus.hi, bus.lo}, head);
      last_result = head;
    end
    @(negedge clk);
    check({tag, "_done_single"}, 64'(bus.done), 64'(0));
    check({tag, "_busy_end"}, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    bit seen_done;
    logic [W-1:0] ra, rb;
    checks      = 0;
    errors      = 0;
    last_result = '0;
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_done", 64'(bus.done), 64'(0));
    check("reset_hilo", {bus.hi, bus.lo}, 64'(0));
    reset = 1'b0;
    @(negedge clk);

    do_op("3x5",   32'd3,          32'd5,          64'h0000_0000_0000_000F, 1'b0);
    do_op("m7x6",  32'hFFFF_FFF9,  32'h0000_0006,  64'hFFFF_FFFF_FFFF_FFD6, 1'b0);
    do_op("minxmin", 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, 1'b0);
    do_op("m1xm1", 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001, 1'b0);
    do_op("maxxmin", 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000, 1'b1);

    // Start pulsed during RUN must not queue a second operation.
    seen_done = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen_done = 1'b1;
    end
    check("no_queued_op", 64'(seen_done), 64'(0));

    // Abort mid-run after a prior result of 15.
    do_op("3x5_again", 32'd3, 32'd5, 64'd15, 1'b0);
    bus.a     = 32'd7;
    bus.b     = 32'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_hilo", {bus.hi, bus.lo}, 64'(0));
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_done", 64'(bus.done), 64'(0));
    @(negedge clk);
    reset       = 1'b0;
    last_result = '0;
    @(negedge clk);
    do_op("2x2", 32'd2, 32'd2, 64'd4, 1'b0);

    do_op("0x1234", 32'd0, 32'h0000_1234, 64'd0, 1'b0);
    do_op("55x0",   32'h55, 32'd0,        64'd0, 1'b0);

    for (int i = 0; i < 4; i++) begin
      ra = $urandom;
      rb = $urandom;
      do_op($sformatf("rand%0d", i), ra, rb, model(ra, rb), 1'b0);
    end

    check("scoreboard_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
